stop_watch_disp_mux_amisha: RTL and testbench

//  Reader side of the stopwatch digit bus: consumes the three BCD digits d2.d1d0
//  and drives a 4-digit, time-multiplexed, common-anode 7-segment display.

---
 rtl/stop_watch_disp_mux_amisha.sv | 152 +++++++++++++++
 tb/tb_stop_watch_disp_mux_amisha.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stop_watch_disp_mux_amisha.sv
// -----------------------------------------------------------------------------
// stop_watch_disp_mux_amisha
//
// Reader side of the stopwatch digit bus. Takes the three BCD digits d2.d1d0
// and drives a 4-digit, time-multiplexed, common-anode 7-segment display.
//
// The digits are captured once per scan frame. A single refresh therefore never
// shows a mix of old and new digits. Each digit slot starts with a short window
// in which every anode is off. This window stops the previous digit's segments
// from ghosting into the next slot.
//
// Ports
//   clk_amisha         in   1  system clock, rising edge
//   reset_n_amisha     in   1  asynchronous reset, active low
//   d2_amisha          in   4  BCD digit, most significant (seconds)
//   d1_amisha          in   4  BCD digit (tenths)
//   d0_amisha          in   4  BCD digit, least significant (hundredths)
//   an_amisha          out  4  anode enables, active low, bit i = slot i
//   sseg_amisha        out  8  {dp,g,f,e,d,c,b,a}, active low
//   frame_tick_amisha  out  1  one-cycle pulse, new digit snapshot taken
//
// Parameters
//   DWELL_CYCLES  clock cycles per digit slot (>= 2)
//   BLANK_CYCLES  blanked cycles at the start of every slot (1..DWELL_CYCLES-1)
//   DP_POS        slot whose decimal point is lit (0..3, 3 never lights)
// -----------------------------------------------------------------------------
module stop_watch_disp_mux_amisha #(
   parameter int DWELL_CYCLES = 50000,
   parameter int BLANK_CYCLES = 1,
   parameter int DP_POS       = 2
) (
   input  logic       clk_amisha,
   input  logic       reset_n_amisha,
   input  logic [3:0] d2_amisha,
   input  logic [3:0] d1_amisha,
   input  logic [3:0] d0_amisha,
   output logic [3:0] an_amisha,
   output logic [7:0] sseg_amisha,
   output logic       frame_tick_amisha
);

   localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
   localparam logic [1:0]       DP_SLOT   = 2'(DP_POS);

   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_slot;
   logic [11:0]      r_snap;
   logic             r_frameTick;
   logic [3:0]       r_an;
   logic [7:0]       r_sseg;

   logic             w_slotEnd;
   logic             w_frameWrap;
   logic             w_blank;
   logic [3:0]       w_digit;
   logic [6:0]       w_segs;
   logic [3:0]       w_anNext;
   logic [7:0]       w_ssegNext;

   // Converts one BCD digit to the active-low segment pattern {g..a}.
   // Any code above 9 shows a dash, so a corrupted bus is visible on the display.
   function automatic logic [6:0] segDecode(input logic [3:0] digit);
      logic [6:0] segs;
      case (digit)
         4'd0:    segs = 7'h40;
         4'd1:    segs = 7'h79;
         4'd2:    segs = 7'h24;
         4'd3:    segs = 7'h30;
         4'd4:    segs = 7'h19;
         4'd5:    segs = 7'h12;
         4'd6:    segs = 7'h02;
         4'd7:    segs = 7'h78;
         4'd8:    segs = 7'h00;
         4'd9:    segs = 7'h10;
         default: segs = 7'h3F;
      endcase
      return segs;
   endfunction

   assign w_slotEnd   = (r_cnt == CNT_LAST);
   assign w_frameWrap = w_slotEnd && (r_slot == 2'd3);

   // Dwell counter and slot index. The slot moves on at the last dwell cycle.
   // The 2-bit slot wraps from 3 back to 0 on its own.
   always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
      if (!reset_n_amisha) begin
         r_cnt  <= '0;
         r_slot <= 2'd0;
      end else if (w_slotEnd) begin
         r_cnt  <= '0;
         r_slot <= r_slot + 2'd1;
      end else begin
         r_cnt  <= r_cnt + CNT_W'(1);
      end
   end

   // The digit snapshot is taken only at the frame wrap, at the end of the
   // unused slot 3. Every visible digit of a frame then comes from the same
   // sample. The tick marks the cycle right after the capture.
   always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
      if (!reset_n_amisha) begin
         r_snap      <= 12'h000;
         r_frameTick <= 1'b0;
      end else begin
         if (w_frameWrap) begin
            r_snap <= {d2_amisha, d1_amisha, d0_amisha};
         end
         r_frameTick <= w_frameWrap;
      end
   end

   // Next display value from the current slot and dwell position.
   // Slot 3 has no digit. It stays dark for its whole dwell so that the three
   // real digits keep the duty cycle of a 4-digit scan. The dp follows the
   // same blanking as the anodes, so DP_POS=3 never lights it.
   always_comb begin
      w_digit    = 4'h0;
      w_blank    = 1'b1;
      w_anNext   = 4'hF;
      w_ssegNext = 8'hFF;
      case (r_slot)
         2'd0:    w_digit = r_snap[3:0];
         2'd1:    w_digit = r_snap[7:4];
         default: w_digit = r_snap[11:8];
      endcase
      w_segs  = segDecode(w_digit);
      w_blank = (r_cnt < BLANK_END) || (r_slot == 2'd3);
      if (!w_blank) begin
         w_anNext   = ~(4'b0001 << r_slot);
         w_ssegNext = {(r_slot != DP_SLOT), w_segs};
      end
   end

   // The display outputs are registered. This keeps the board pins glitch free
   // and adds one cycle of latency after the slot/counter state.
   always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
      if (!reset_n_amisha) begin
         r_an   <= 4'hF;
         r_sseg <= 8'hFF;
      end else begin
         r_an   <= w_anNext;
         r_sseg <= w_ssegNext;
      end
   end

   assign an_amisha         = r_an;
   assign sseg_amisha       = r_sseg;
   assign frame_tick_amisha = r_frameTick;

endmodule

// File: tb/tb_stop_watch_disp_mux_amisha.sv
// -----------------------------------------------------------------------------
// tb_stop_watch_disp_mux_amisha
//
// Self-checking bench for the stopwatch display multiplexer. It uses a short
// dwell of 4 cycles and 1 blank cycle, with the decimal point on slot 2.
//
// The reference model works from a count of rising edges since reset release.
// Each edge is mapped to a position inside a 16-cycle frame. The model keeps
// its own digit snapshot, refreshed at every frame boundary.
// -----------------------------------------------------------------------------
module tb_stop_watch_disp_mux_amisha;

   localparam int DWELL = 4;
   localparam int BLANK = 1;
   localparam int DPP   = 2;
   localparam int FRAME = 4 * DWELL;

   logic       clk = 1'b0;
   logic       rstN;
   logic [3:0] d2;
   logic [3:0] d1;
   logic [3:0] d0;
   logic [3:0] an;
   logic [7:0] sseg;
   logic       frameTick;

   int         nVec = 0;
   int         nErr = 0;
   int         k = 0;
   logic [3:0] mSnap [3];
   logic [3:0] expAn;
   logic [7:0] expSseg;
   logic       expTick;
   logic [6:0] segTable [10];

   stop_watch_disp_mux_amisha #(
      .DWELL_CYCLES(DWELL),
      .BLANK_CYCLES(BLANK),
      .DP_POS(DPP)
   ) dut (
      .clk_amisha(clk),
      .reset_n_amisha(rstN),
      .d2_amisha(d2),
      .d1_amisha(d1),
      .d0_amisha(d0),
      .an_amisha(an),
      .sseg_amisha(sseg),
      .frame_tick_amisha(frameTick)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Global watchdog so the bench never hangs.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired, nothing observed");
      $fatal(1, "[TB] watchdog");
   end

   // Advance one clock edge and compute the expected outputs for that edge.
   // The expected digits come from the snapshot held before this edge. The
   // snapshot is refreshed only at a frame boundary.
   task automatic tick();
      int phase;
      int slot;
      int cnt;
      @(posedge clk);
      if (!rstN) begin
         k       = 0;
         mSnap   = '{default: 4'h0};
         expAn   = 4'hF;
         expSseg = 8'hFF;
         expTick = 1'b0;
      end else begin
         k       = k + 1;
         phase   = (k - 1) % FRAME;
         slot    = phase / DWELL;
         cnt     = phase % DWELL;
         expTick = ((k % FRAME) == 0);
         if (cnt < BLANK || slot == 3) begin
            expAn   = 4'hF;
            expSseg = 8'hFF;
         end else begin
            expAn       = 4'hF;
            expAn[slot] = 1'b0;
            expSseg     = {(slot == DPP) ? 1'b0 : 1'b1,
                           (mSnap[slot] <= 4'd9) ? segTable[mSnap[slot]] : 7'h3F};
         end
         if ((k % FRAME) == 0) begin
            mSnap[0] = d0;
            mSnap[1] = d1;
            mSnap[2] = d2;
         end
      end
      #1;
   endtask

   // Hold reset, then release it. The first frame must show "0.00".
   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         tick();
         nVec++;
         if ({an, sseg, frameTick} !== {4'hF, 8'hFF, 1'b0}) begin
            nErr++;
            $display("[TB] FAIL reset_hold an=%b sseg=%h tick=%b required an=1111 sseg=ff tick=0",
                     an, sseg, frameTick);
         end
      end
      rstN = 1'b1;
      for (int i = 0; i < FRAME; i++) begin
         tick();
         nVec++;
         if ({an, sseg, frameTick} !== {expAn, expSseg, expTick}) begin
            nErr++;
            $display("[TB] FAIL reset_frame k=%0d an=%b sseg=%h tick=%b required an=%b sseg=%h tick=%b",
                     k, an, sseg, frameTick, expAn, expSseg, expTick);
         end
         if (k == 10) begin
            nVec++;
            if ({an, sseg} !== {4'b1011, 8'h40}) begin
               nErr++;
               $display("[TB] FAIL reset_slot2 an=%b sseg=%h required an=1011 sseg=40", an, sseg);
            end
         end
      end
   endtask

   // Show 3.21 once the next frame has captured the new digits.
   task automatic test_digits();
      d2 = 4'd3;
      d1 = 4'd2;
      d0 = 4'd1;
      for (int i = 0; i < 2 * FRAME; i++) begin
         tick();
         nVec++;
         if ({an, sseg, frameTick} !== {expAn, expSseg, expTick}) begin
            nErr++;
            $display("[TB] FAIL digits k=%0d an=%b sseg=%h tick=%b required an=%b sseg=%h tick=%b",
                     k, an, sseg, frameTick, expAn, expSseg, expTick);
         end
         if (k == 34) begin
            nVec++;
            if ({an, sseg} !== {4'b1110, 8'hF9}) begin
               nErr++;
               $display("[TB] FAIL digits_slot0 an=%b sseg=%h required an=1110 sseg=f9", an, sseg);
            end
         end
         if (k == 42) begin
            nVec++;
            if ({an, sseg} !== {4'b1011, 8'h30}) begin
               nErr++;
               $display("[TB] FAIL digits_slot2 an=%b sseg=%h required an=1011 sseg=30", an, sseg);
            end
         end
      end
   endtask

   // Change d0 during slot 1. Nothing changes on screen until the next frame.
   task automatic test_midframe_change();
      for (int i = 0; i < 2 * FRAME; i++) begin
         tick();
         if (k == 54) d0 = 4'd7;
         nVec++;
         if ({an, sseg, frameTick} !== {expAn, expSseg, expTick}) begin
            nErr++;
            $display("[TB] FAIL midframe k=%0d an=%b sseg=%h tick=%b required an=%b sseg=%h tick=%b",
                     k, an, sseg, frameTick, expAn, expSseg, expTick);
         end
         if (k == 66) begin
            nVec++;
            if (sseg !== 8'hF8) begin
               nErr++;
               $display("[TB] FAIL midframe_new sseg=%h required f8", sseg);
            end
         end
      end
   endtask

   // An invalid BCD digit on d1 shows a dash with the dp off.
   task automatic test_invalid();
      d1 = 4'hC;
      for (int i = 0; i < 2 * FRAME; i++) begin
         tick();
         nVec++;
         if ({an, sseg, frameTick} !== {expAn, expSseg, expTick}) begin
            nErr++;
            $display("[TB] FAIL invalid k=%0d an=%b sseg=%h tick=%b required an=%b sseg=%h tick=%b",
                     k, an, sseg, frameTick, expAn, expSseg, expTick);
         end
         if (k == 102) begin
            nVec++;
            if ({an, sseg} !== {4'b1101, 8'hBF}) begin
               nErr++;
               $display("[TB] FAIL invalid_dash an=%b sseg=%h required an=1101 sseg=bf", an, sseg);
            end
         end
      end
   endtask

   // Assert reset in the middle of slot 2. After release, scanning must
   // restart from slot 0 with a cleared snapshot.
   task automatic test_reset_midslot();
      for (int i = 0; i < FRAME && (k % FRAME) != 10; i++) begin
         tick();
         nVec++;
         if ({an, sseg, frameTick} !== {expAn, expSseg, expTick}) begin
            nErr++;
            $display("[TB] FAIL pre_reset k=%0d an=%b sseg=%h required an=%b sseg=%h",
                     k, an, sseg, expAn, expSseg);
         end
      end
      rstN = 1'b0;
      #1;
      nVec++;
      if ({an, sseg, frameTick} !== {4'hF, 8'hFF, 1'b0}) begin
         nErr++;
         $display("[TB] FAIL async_reset an=%b sseg=%h tick=%b required an=1111 sseg=ff tick=0",
                  an, sseg, frameTick);
      end
      tick();
      rstN = 1'b1;
      for (int i = 0; i < FRAME + 2; i++) begin
         tick();
         nVec++;
         if ({an, sseg, frameTick} !== {expAn, expSseg, expTick}) begin
            nErr++;
            $display("[TB] FAIL post_reset k=%0d an=%b sseg=%h tick=%b required an=%b sseg=%h tick=%b",
                     k, an, sseg, frameTick, expAn, expSseg, expTick);
         end
         if (k == 2) begin
            nVec++;
            if ({an, sseg} !== {4'b1110, 8'hC0}) begin
               nErr++;
               $display("[TB] FAIL post_reset_slot0 an=%b sseg=%h required an=1110 sseg=c0", an, sseg);
            end
         end
      end
   endtask

   // Random digit changes at random times. The outputs are checked against the
   // model on every cycle. The bench also checks that at most one anode is low,
   // that the frame tick period is 16 cycles, and that each anode is low for
   // DWELL-BLANK cycles per frame.
   task automatic test_random();
      int lowCnt [4];
      bit started;
      int lastTickK;
      started   = 1'b0;
      lastTickK = -1;
      lowCnt    = '{default: 0};
      for (int i = 0; i < 24 * FRAME; i++) begin
         tick();
         if ($urandom_range(0, 7) == 0) d0 = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) d1 = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) d2 = 4'($urandom_range(0, 15));
         nVec++;
         if ({an, sseg, frameTick} !== {expAn, expSseg, expTick}) begin
            nErr++;
            $display("[TB] FAIL random k=%0d an=%b sseg=%h tick=%b required an=%b sseg=%h tick=%b",
                     k, an, sseg, frameTick, expAn, expSseg, expTick);
         end
         nVec++;
         if ($countones(~an) > 1) begin
            nErr++;
            $display("[TB] FAIL onehot an=%b required at most one low", an);
         end
         for (int j = 0; j < 4; j++) begin
            if (an[j] == 1'b0) lowCnt[j]++;
         end
         if (frameTick === 1'b1) begin
            if (started) begin
               for (int j = 0; j < 3; j++) begin
                  nVec++;
                  if (lowCnt[j] != DWELL - BLANK) begin
                     nErr++;
                     $display("[TB] FAIL anode_dwell an[%0d] low %0d cycles required %0d",
                              j, lowCnt[j], DWELL - BLANK);
                  end
               end
               nVec++;
               if (lowCnt[3] != 0) begin
                  nErr++;
                  $display("[TB] FAIL anode3_dwell low %0d cycles required 0", lowCnt[3]);
               end
            end
            if (lastTickK >= 0) begin
               nVec++;
               if (k - lastTickK != FRAME) begin
                  nErr++;
                  $display("[TB] FAIL tick_period got %0d required %0d", k - lastTickK, FRAME);
               end
            end
            lastTickK = k;
            started   = 1'b1;
            lowCnt    = '{default: 0};
         end
      end
   endtask

   // Runs the scenarios in order and prints the summary line.
   initial begin
      segTable = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      mSnap    = '{default: 4'h0};
      rstN     = 1'b0;
      d2       = 4'd0;
      d1       = 4'd0;
      d0       = 4'd0;
      test_reset();
      test_digits();
      test_midframe_change();
      test_invalid();
      test_reset_midslot();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
